// File: rtl/svm_sequencer.sv
// svm_sequencer: job controller for the hw_svm systolic dot-product pipeline.
// Credit-gated operand issue, marker delay line and output result FIFO.
module svm_sequencer #(
    parameter int NUM_SV     = 10,
    parameter int PIPE_LAT   = 16,
    parameter int ACCUM_SIZE = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 8,
    localparam int SV_W  = (NUM_SV > 1) ? $clog2(NUM_SV) : 1,
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IDX_W-1:0]      num_inst,
    output logic                  busy,
    output logic                  done,
    output logic                  issue_valid,
    output logic [SV_W-1:0]       sv_idx,
    output logic [IDX_W-1:0]      test_idx,
    output logic                  issue_first,
    output logic                  issue_last,
    input  logic [ACCUM_SIZE-1:0] result_in,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACCUM_SIZE-1:0] res_data,
    output logic                  res_label,
    output logic [IDX_W-1:0]      res_idx
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [SV_W-1:0]  sv_q, sv_d;
    logic [IDX_W-1:0] test_q, test_d;
    logic [IDX_W-1:0] num_q, num_d;
    logic [IDX_W-1:0] popped_q, popped_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic             reserve;
    logic             pop;
    logic             push;
    logic             at_last;

    logic [PIPE_LAT-1:0] mark_vld_q;
    logic [IDX_W-1:0]    mark_idx_q [PIPE_LAT];

    logic [ACCUM_SIZE-1:0] mem_data_q [FIFO_DEPTH];
    logic [IDX_W-1:0]      mem_idx_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_q, wr_q;
    logic [CNT_W-1:0]      count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign at_last     = (sv_q == SV_W'(NUM_SV - 1));
    assign issue_valid = valid_q;
    assign sv_idx      = sv_q;
    assign test_idx    = test_q;
    assign issue_first = valid_q && (sv_q == '0);
    assign issue_last  = valid_q && at_last;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    assign res_valid = (count_q != '0);
    assign pop       = res_valid && res_ready;
    assign push      = mark_vld_q[PIPE_LAT-1];
    assign res_data  = res_valid ? mem_data_q[rd_q] : '0;
    assign res_idx   = res_valid ? mem_idx_q[rd_q] : '0;
    assign res_label = res_valid && !res_data[ACCUM_SIZE-1];

    // Each instance boundary reserves one FIFO slot so captures never overflow.
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        sv_d     = sv_q;
        test_d   = test_q;
        num_d    = num_q;
        popped_d = popped_q + IDX_W'(pop);
        reserve  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d    = num_inst;
                    sv_d     = '0;
                    test_d   = '0;
                    popped_d = '0;
                    if (num_inst == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        valid_d = 1'b1;
                        reserve = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (valid_q && !at_last) begin
                    valid_d = 1'b1;
                    sv_d    = sv_q + SV_W'(1);
                end else if (valid_q) begin
                    sv_d = '0;
                    if (test_q == num_q - IDX_W'(1)) begin
                        state_d = DRAIN;
                    end else begin
                        test_d = test_q + IDX_W'(1);
                        if (credits_q != '0) begin
                            valid_d = 1'b1;
                            reserve = 1'b1;
                        end
                    end
                end else if (credits_q != '0) begin
                    valid_d = 1'b1;
                    reserve = 1'b1;
                end
            end
            DRAIN: begin
                if (pop && (popped_q + IDX_W'(1) == num_q)) state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
        credits_d = credits_q;
        if (reserve && !pop) credits_d = credits_q - CNT_W'(1);
        else if (pop && !reserve) credits_d = credits_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            sv_q      <= '0;
            test_q    <= '0;
            num_q     <= '0;
            popped_q  <= '0;
            credits_q <= CNT_W'(FIFO_DEPTH);
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            sv_q      <= sv_d;
            test_q    <= test_d;
            num_q     <= num_d;
            popped_q  <= popped_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mark_vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) mark_idx_q[i] <= '0;
        end else begin
            mark_vld_q[0] <= issue_last;
            mark_idx_q[0] <= issue_last ? test_q : '0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                mark_vld_q[i] <= mark_vld_q[i-1];
                mark_idx_q[i] <= mark_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop) rd_q <= ptr_inc(rd_q);
            if (push && !pop) count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_q] <= result_in;
            mem_idx_q[wr_q]  <= mark_idx_q[PIPE_LAT-1];
        end
    end

endmodule

// File: doc/svm_sequencer.md
# svm_sequencer

Controller for the hw_svm systolic dot-product pipeline. It accepts a job request, issues (test instance, support vector) index pairs to the pipeline and its operand memories, and tracks each instance's result through the pipeline latency with a marker delay line. It captures finished accumulator values into an output FIFO and delivers them over a valid/ready stream with a sign-derived class label. Issue is credit-gated because the pipeline cannot stall, so results are never dropped under downstream backpressure.

## Interface
- NUM_SV, 10, support vectors per instance (inner loop length)
- PIPE_LAT, 16, cycles from an issue to the pipeline tail result (NUM_FEAT)
- ACCUM_SIZE, 64, result width
- FIFO_DEPTH, 4, output result FIFO entries (≥1)
- IDX_W, 8, instance index / count width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled only in IDLE
- num_inst  in  IDX_W  instances in job, sampled with start
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at job completion
- issue_valid  out  1  pipeline operand slot valid this cycle
- sv_idx  out  $clog2(NUM_SV)  support vector index
- test_idx  out  IDX_W  test instance index
- issue_first  out  1  issue_valid && sv_idx==0 (clears accumulator chain)
- issue_last  out  1  issue_valid && sv_idx==NUM_SV-1
- result_in  in  ACCUM_SIZE  pipeline tail accumulator
- res_valid  out  1  output entry available
- res_ready  in  1  downstream accepts
- res_data  out  ACCUM_SIZE  captured accumulator, signed
- res_label  out  1  ~res_data[ACCUM_SIZE-1] (1 = non-negative)
- res_idx  out  IDX_W  instance index of res_data

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when start=1, latch num_inst. If num_inst==0, go to DONE. Otherwise go to ISSUE with sv_idx=0, test_idx=0, credits=FIFO_DEPTH.
- ISSUE: at an instance boundary (sv_idx==0), issue only if credits>0, and decrement credits in that cycle. Otherwise hold issue_valid=0 (bubble) and keep the indices.
- ISSUE, mid-instance (sv_idx≠0): issue every cycle unconditionally. An instance's NUM_SV slots are always contiguous.
- On issue_last, wrap sv_idx to 0 and increment test_idx. When test_idx==num_inst-1 and issue_last, go to DRAIN.
- Marker delay line: a PIPE_LAT-deep shift register carrying {issue_last, test_idx}, with zeros in bubbles.
- When a marker emerges, push {result_in, idx} into the FIFO. A push is guaranteed to find a free entry because of credits.
- Credits increment on each res_valid&&res_ready pop. A simultaneous reserve and pop leaves the count unchanged. Credits never exceed FIFO_DEPTH.
- DRAIN: wait until all num_inst results have been popped, then go to DONE.
- DONE: drive done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored. num_inst is not resampled during a job.
- Output stream: res_data, res_label and res_idx are held stable while res_valid && !res_ready. Entries leave in FIFO order, which equals instance order.
- Reset (any time, including mid-job): state=IDLE, busy=0, done=0, issue_valid=0, sv_idx=0, test_idx=0, FIFO emptied (res_valid=0), delay line cleared, credits=FIFO_DEPTH. res_data, res_idx and res_label reset to 0.

## Timing
- Issue outputs are registered. If start is sampled at edge E, the first issue (sv 0, inst 0) is valid in the cycle following E.
- A marker from an issue_last in cycle t samples result_in in cycle t+PIPE_LAT. res_valid rises in cycle t+PIPE_LAT+1.
- FIFO push and pop in the same cycle are both honoured. A push into an empty FIFO is not visible until the next cycle (no bypass).
- done asserts the cycle after the final pop is accepted.
- Single instance, res_ready=1, start sampled at edge 0:
  - issues in cycles 1–10
  - capture in cycle 26
  - res_valid in cycle 27
  - done in cycle 28
- Back-to-back instances with credits available issue with no bubbles, giving N*NUM_SV contiguous issue cycles.

## Test plan
- num_inst=1, result_in=64'h5 at capture, res_ready=1 -> issue cycles 1–10 with sv_idx 0..9; res_valid in cycle 27 with res_data=5, res_label=1, res_idx=0; done in cycle 28 only.
- num_inst=3, res_ready=1 -> 30 contiguous issue cycles; issue_first and issue_last each pulse 3 times; res_idx 0,1,2 in order; busy low after done.
- num_inst=6, FIFO_DEPTH=4, res_ready=0 until cycle 80, then 1 -> after 4 instances issue_valid stays 0 (sv_idx=0, test_idx=4) until the first pop; all 6 results delivered in order; none lost.
- result_in=64'hFFFF_FFFF_FFFF_FFFE at capture -> res_label=0 and res_data unchanged; res_data held stable while res_ready=0 for 5 cycles.
- num_inst=0 -> done the cycle after start; no issue_valid and no res_valid ever.
- rst_n pulsed low during cycle 15 of a 3-instance job, then a new start with num_inst=1 -> all outputs return to reset values immediately; no stale result appears; the new job matches the first scenario's timing. A start pulsed while busy has no effect.
